seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_det_core.sv | 63 ++++++
 rtl/seq_det_ctrl.sv | 114 +++++++++++
 tb/tb_seq_det_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial pattern detector.
//   state_e : session FSM states (IDLE, LOAD, RUN, DONE)
//   PAT_W   : pattern / history width
//   CNT_W   : bit-count, bit-limit and match-count width
//   FILL_W  : width of the history fill counter (must hold PAT_W)
// ----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;
    localparam int FILL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_det_core.sv
// ----------------------------------------------------------------------------
// seq_det_core
// History shift register, fill counter and pattern compare.
// Build option: SEQ_DET_OVERLAP_EN -- when defined, history and fill are kept
// after a match so overlapping occurrences are counted; when undefined the
// fill counter restarts so each match needs PAT_W fresh bits.
// Ports:
//   clk, rst    : clock, async active-high reset
//   clr_i       : restart history and fill (session start)
//   shift_i     : consume din_i this cycle
//   din_i       : serial data bit
//   pattern_i   : latched target pattern, MSB first
//   hit_o       : combinational, high when the bit being shifted completes
//                 a match (post-shift fill full and history equals pattern)
// ----------------------------------------------------------------------------
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             din_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             hit_o
);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_sh;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        fill_sh = fill_q;
        hit_o   = 1'b0;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d  = {hist_q[PAT_W-2:0], din_i};
            fill_sh = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
            // Compare uses post-shift values so the match lands on the edge
            // that samples the final pattern bit.
            hit_o   = (fill_sh == FILL_W'(PAT_W)) && (hist_d == pattern_i);
`ifdef SEQ_DET_OVERLAP_EN
            fill_d  = fill_sh;
`else
            fill_d  = hit_o ? '0 : fill_sh;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// ----------------------------------------------------------------------------
// seq_det_ctrl
// Session controller for a serial 4-bit pattern detector.
// Build option: SEQ_DET_OVERLAP_EN (see seq_det_core) selects whether
// overlapping matches are counted.
// Ports:
//   clk, rst     : clock, async active-high reset
//   start        : session request, honoured only in IDLE
//   pattern      : target sequence (MSB first), latched on start
//   bit_limit    : number of valid din bits in the session, latched on start
//   din/din_valid: serial data, consumed only in RUN
//   busy         : high in LOAD and RUN
//   done         : one-cycle pulse at session end
//   match        : one-cycle pulse per detected pattern
//   match_count  : saturating match count of current/last session
// ----------------------------------------------------------------------------
module seq_det_ctrl
    import seq_det_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] bit_limit,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] lim_q, bitcnt_q, mcnt_q;
    logic             busy_q, done_q, match_q;

    logic             accept, shift, hit;
    logic [CNT_W-1:0] bitcnt_inc;

    assign accept     = (state_q == IDLE) && start;
    assign shift      = (state_q == RUN) && din_valid;
    assign bitcnt_inc = bitcnt_q + 1'b1;

    seq_det_core u_core (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept),
        .shift_i   (shift),
        .din_i     (din),
        .pattern_i (pat_q),
        .hit_o     (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            lim_q    <= '0;
            bitcnt_q <= '0;
            mcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            match_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_q    <= pattern;
                        lim_q    <= bit_limit;
                        bitcnt_q <= '0;
                        mcnt_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (lim_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (din_valid) begin
                        bitcnt_q <= bitcnt_inc;
                        if (hit) begin
                            match_q <= 1'b1;
                            if (mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
                        end
                        // Final bit is still evaluated above before leaving RUN.
                        if (bitcnt_inc == lim_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign match_count = mcnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_det_ctrl
// Scoreboard bench for seq_det_ctrl. Stimulus pushes the expected match/done
// events (with the match_count each should show) into a queue; a monitor on
// the falling edge pops and compares every match or done pulse the DUT emits.
// Honours SEQ_DET_OVERLAP_EN for the expected match positions.
// ----------------------------------------------------------------------------
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = '0;
    logic [7:0] bit_limit = '0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       busy, done, match;
    logic [7:0] match_count;

    seq_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern     (pattern),
        .bit_limit   (bit_limit),
        .din         (din),
        .din_valid   (din_valid),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [7:0] cnt;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input logic is_done, input logic [7:0] cnt);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL %s_event: unexpected pulse at %0t (count %0d), none expected",
                     is_done ? "done" : "match", $time, cnt);
        end else begin
            e = q.pop_front();
            if (e.is_done !== is_done || e.cnt !== cnt) begin
                n_err++;
                $display("FAIL %s_event: got done=%0d count=%0d, want done=%0d count=%0d at %0t",
                         is_done ? "done" : "match", is_done, cnt, e.is_done, e.cnt, $time);
            end
        end
    endtask

    // Monitor: match is popped before done since both can pulse together.
    always @(negedge clk) begin
        if (!rst) begin
            if (match) pop_cmp(1'b0, match_count);
            if (done)  pop_cmp(1'b1, match_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] p, input logic [7:0] l, input bit load_noise);
        start = 1'b1; pattern = p; bit_limit = l;
        tick();
        start = 1'b0; pattern = ~p; bit_limit = 8'hAA;   // late changes must not matter
        chk("busy_load", busy, 1);
        chk("cnt_clr", match_count, 0);
        exp_cnt = 0;
        if (l == 8'd0) q.push_back('{1'b1, 8'd0});
        if (load_noise) begin din_valid = 1'b1; din = 1'b1; end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit hit, input bit last);
        if (hit) begin exp_cnt++; q.push_back('{1'b0, 8'(exp_cnt)}); end
        if (last) q.push_back('{1'b1, 8'(exp_cnt)});
        din = b; din_valid = 1'b1;
        tick();
        din_valid = 1'b0; din = ~b;
    endtask

    task automatic gap();
        din_valid = 1'b0; din = 1'($urandom);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] stream;
        stream = 7'b1011011;

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_count", match_count, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Overlap stream, din_valid held high during LOAD (must be ignored)
        do_start(4'b1011, 8'd7, 1'b1);
        for (int k = 1; k <= 7; k++)
            send_bit(stream[7-k], (k == 4) || (OVL && k == 7), k == 7);
        tick();
        chk("ovl_busy_idle", busy, 0);
        chk("ovl_count", match_count, OVL ? 2 : 1);
        tick(); tick();
        chk("ovl_count_hold", match_count, OVL ? 2 : 1);

        // Same stream with gaps; start pulse with a new pattern mid-RUN
        do_start(4'b1011, 8'd7, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            send_bit(stream[7-k], (k == 4) || (OVL && k == 7), k == 7);
            if (k == 2) begin
                start = 1'b1; pattern = 4'b0000; bit_limit = 8'd3;
                tick();
                start = 1'b0;
            end else if (k < 7) begin
                gap();
            end
        end
        tick();
        chk("gap_count", match_count, OVL ? 2 : 1);

        // bit_limit = 0: LOAD straight to DONE
        do_start(4'b0110, 8'd0, 1'b0);
        chk("l0_busy_done", busy, 0);
        chk("l0_done", done, 1);
        tick();
        chk("l0_done_clear", done, 0);
        chk("l0_count", match_count, 0);

        // Long all-zero session
        do_start(4'b0000, 8'd255, 1'b0);
        for (int k = 1; k <= 255; k++)
            send_bit(1'b0, OVL ? (k >= 4) : (k % 4 == 0), k == 255);
        tick();
        chk("sat_count", match_count, OVL ? 252 : 63);

        // Second zero-pattern session: counter restarts from 0
        do_start(4'b0000, 8'd4, 1'b0);
        for (int k = 1; k <= 4; k++)
            send_bit(1'b0, k == 4, k == 4);
        tick();
        chk("sess2_count", match_count, 1);

        // Reset mid-RUN: no done, counters cleared
        do_start(4'b1011, 8'd20, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", match_count, 0);
        chk("mid_rst_done", done, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_done", done, 0);

        // Normal session after reset
        do_start(4'b0110, 8'd4, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1);
        tick(); tick();
        chk("post_rst_count", match_count, 1);

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
